red_pitaya_fads_mc: RTL and testbench

Multi-channel, parametrised fluorescence-activated droplet sorter for the Red Pitaya ADC clock domain. It gates droplets on channel 0 and tracks the per-droplet peak on every channel. A droplet is classified by gate width plus per-channel peak windows, and a qualifying droplet produces a delayed, fixed-length sort pulse toward the ASG / HV amplifier. Statistics counters and all thresholds are exposed on the system bus.

---
 rtl/red_pitaya_fads_mc_if.sv | 16 +
 rtl/red_pitaya_fads_mc.sv | 262 ++++++++++++++++++++++++++
 tb/tb_red_pitaya_fads_mc.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/red_pitaya_fads_mc_if.sv
// System bus bundle between the PS bus bridge and the FADS register file.
interface red_pitaya_fads_mc_if;
    logic [31:0] sys_addr;
    logic [31:0] sys_wdata;
    logic [3:0]  sys_sel;
    logic        sys_wen;
    logic        sys_ren;
    logic [31:0] sys_rdata;
    logic        sys_err;
    logic        sys_ack;

    modport master (output sys_addr, sys_wdata, sys_sel, sys_wen, sys_ren,
                    input  sys_rdata, sys_err, sys_ack);
    modport slave  (input  sys_addr, sys_wdata, sys_sel, sys_wen, sys_ren,
                    output sys_rdata, sys_err, sys_ack);
endinterface

// File: rtl/red_pitaya_fads_mc.sv
// Multi-channel droplet sorter: gates on channel 0, tracks per-channel peaks,
// classifies each droplet and fires a delayed fixed-length sort pulse.
// Optional feature macro FADS_SORT_DELAY_EN adds the DELAY state and the
// sort_delay register; without it EVAL goes straight to SORT.

// Per-channel peak tracker and window check.
module red_pitaya_fads_mc_lane #(
    parameter int DW = 14
) (
    input  logic          adc_clk_i,
    input  logic          adc_rst_i,
    input  logic          start,
    input  logic          track,
    input  logic [DW-1:0] sample,
    input  logic [DW-1:0] win_low,
    input  logic [DW-1:0] win_high,
    output logic [DW-1:0] peak,
    output logic          in_win
);
    // Seed on droplet start, then keep the signed maximum while acquiring
    always_ff @(posedge adc_clk_i) begin
        if (adc_rst_i)                                       peak <= '0;
        else if (start)                                      peak <= sample;
        else if (track && ($signed(sample) > $signed(peak))) peak <= sample;
    end

    assign in_win = ($signed(peak) >= $signed(win_low)) && ($signed(peak) < $signed(win_high));
endmodule

module red_pitaya_fads_mc #(
    parameter int CH = 2,
    parameter int DW = 14,
    parameter int CW = 32
) (
    input  logic                adc_clk_i,
    input  logic                adc_rst_i,
    input  logic [CH*DW-1:0]    adc_dat_i,
    output logic                sort_trig_o,
    output logic                sort_busy_o,
    red_pitaya_fads_mc_if.slave sys
);
    typedef enum logic [2:0] {WAIT = 3'd0, ACQ = 3'd1, EVAL = 3'd2, DELAY = 3'd3, SORT = 3'd4} state_t;
    state_t state_q, state_d;

    logic [CH-1:0][DW-1:0] samp, peak, ch_low, ch_high;
    logic [CH-1:0]         in_win, ch_mask;
    logic                  acq_en, sort_en;
    logic [DW-1:0]         min_thr;
    logic [CW-1:0]         min_width, low_width, high_width, sort_dur;
`ifdef FADS_SORT_DELAY_EN
    logic [CW-1:0]         sort_delay;
`endif
    logic [CW-1:0]         width, cnt;
    logic [CW:0]           cnt_p1;
    logic [CW-1:0]         c_tot, c_pos, c_short, c_long, c_sorted, c_missed;
    logic                  above, above_q, rise, pos, start, track, clr;
    logic                  inc_tot, inc_pos, inc_short, inc_long, inc_sorted;
    logic [19:0]           addr;
    logic [31:0]           rd;
    logic                  unused_bits;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (&v) ? v : v + CW'(1);
    endfunction

    assign samp        = adc_dat_i;
    assign addr        = sys.sys_addr[19:0];
    assign unused_bits = ^{sys.sys_sel, sys.sys_addr[31:20], sys.sys_wdata};
    assign above       = $signed(samp[0]) >= $signed(min_thr);
    assign rise        = above && !above_q;
    assign pos         = (width >= low_width) && (width < high_width) && (&(in_win | ~ch_mask));
    assign cnt_p1      = {1'b0, cnt} + {{CW{1'b0}}, 1'b1};
    assign sort_busy_o = (state_q == DELAY) || (state_q == SORT);
    assign clr         = sys.sys_wen && (addr == 20'h0) && sys.sys_wdata[2];
    assign sys.sys_err = 1'b0;

    for (genvar c = 0; c < CH; c++) begin : g_lane
        red_pitaya_fads_mc_lane #(.DW(DW)) u_lane (
            .adc_clk_i (adc_clk_i),
            .adc_rst_i (adc_rst_i),
            .start     (start),
            .track     (track),
            .sample    (samp[c]),
            .win_low   (ch_low[c]),
            .win_high  (ch_high[c]),
            .peak      (peak[c]),
            .in_win    (in_win[c])
        );
    end

    // State register and gate history for rising-edge detection
    always_ff @(posedge adc_clk_i) begin
        if (adc_rst_i) begin
            state_q <= WAIT;
            above_q <= 1'b0;
        end else begin
            state_q <= state_d;
            above_q <= above;
        end
    end

    // Next-state logic and per-droplet counter strobes
    always_comb begin
        state_d    = state_q;
        start      = 1'b0;
        track      = 1'b0;
        inc_tot    = 1'b0;
        inc_pos    = 1'b0;
        inc_short  = 1'b0;
        inc_long   = 1'b0;
        inc_sorted = 1'b0;
        case (state_q)
            WAIT: if (acq_en && above) begin
                state_d = ACQ;
                start   = 1'b1;
            end
            ACQ: if (above) track = 1'b1;
                 else       state_d = EVAL;
            EVAL: begin
                state_d = WAIT;
                if (width >= min_width) begin
                    inc_tot   = 1'b1;
                    inc_short = width < low_width;
                    inc_long  = width >= high_width;
                    inc_pos   = pos;
                    if (pos && sort_en && (sort_dur != '0)) begin
                        inc_sorted = 1'b1;
`ifdef FADS_SORT_DELAY_EN
                        state_d    = DELAY;
`else
                        state_d    = SORT;
`endif
                    end
                end
            end
`ifdef FADS_SORT_DELAY_EN
            DELAY: if (cnt >= sort_delay) state_d = SORT;
`else
            DELAY: state_d = WAIT;
`endif
            // A duration shrunk to zero mid-pulse still terminates
            SORT: if (cnt_p1 >= {1'b0, sort_dur}) state_d = WAIT;
            default: state_d = WAIT;
        endcase
    end

    // Droplet width, DELAY/SORT cycle counter and registered sort pulse
    always_ff @(posedge adc_clk_i) begin
        if (adc_rst_i) begin
            width       <= '0;
            cnt         <= '0;
            sort_trig_o <= 1'b0;
        end else begin
            if (start)      width <= CW'(1);
            else if (track) width <= sat_inc(width);
            cnt         <= (state_d != state_q) ? '0 : sat_inc(cnt);
            sort_trig_o <= (state_d == SORT);
        end
    end

    // Statistics counters; clear beats any same-cycle increment
    always_ff @(posedge adc_clk_i) begin
        if (adc_rst_i || clr) begin
            c_tot    <= '0;
            c_pos    <= '0;
            c_short  <= '0;
            c_long   <= '0;
            c_sorted <= '0;
            c_missed <= '0;
        end else begin
            if (inc_tot)               c_tot    <= sat_inc(c_tot);
            if (inc_pos)               c_pos    <= sat_inc(c_pos);
            if (inc_short)             c_short  <= sat_inc(c_short);
            if (inc_long)              c_long   <= sat_inc(c_long);
            if (inc_sorted)            c_sorted <= sat_inc(c_sorted);
            if (rise && sort_busy_o)   c_missed <= sat_inc(c_missed);
        end
    end

    // Configuration registers, full-word writes
    always_ff @(posedge adc_clk_i) begin
        if (adc_rst_i) begin
            acq_en     <= 1'b1;
            sort_en    <= 1'b0;
            ch_mask    <= '1;
            min_thr    <= DW'(15);
            min_width  <= CW'(1);
            low_width  <= '0;
            high_width <= '1;
            sort_dur   <= CW'(125);
`ifdef FADS_SORT_DELAY_EN
            sort_delay <= '0;
`endif
            for (int c = 0; c < CH; c++) begin
                ch_low[c]  <= DW'(16);
                ch_high[c] <= DW'(255);
            end
        end else if (sys.sys_wen) begin
            case (addr)
                20'h00: begin
                    acq_en  <= sys.sys_wdata[0];
                    sort_en <= sys.sys_wdata[1];
                end
                20'h08: ch_mask    <= sys.sys_wdata[CH-1:0];
                20'h0C: min_thr    <= sys.sys_wdata[DW-1:0];
                20'h10: min_width  <= sys.sys_wdata[CW-1:0];
                20'h14: low_width  <= sys.sys_wdata[CW-1:0];
                20'h18: high_width <= sys.sys_wdata[CW-1:0];
`ifdef FADS_SORT_DELAY_EN
                20'h1C: sort_delay <= sys.sys_wdata[CW-1:0];
`endif
                20'h20: sort_dur   <= sys.sys_wdata[CW-1:0];
                default: ;
            endcase
            for (int c = 0; c < CH; c++) begin
                if (addr == 20'(64 + 8*c)) ch_low[c]  <= sys.sys_wdata[DW-1:0];
                if (addr == 20'(68 + 8*c)) ch_high[c] <= sys.sys_wdata[DW-1:0];
            end
        end
    end

    // Read decode: signed fields sign-extended, unmapped addresses read 0
    always_comb begin
        rd = '0;
        case (addr)
            20'h000: rd = {30'd0, sort_en, acq_en};
            20'h004: rd = {27'd0, sort_trig_o, 1'b0, state_q};
            20'h008: rd = 32'(ch_mask);
            20'h00C: rd = 32'($signed(min_thr));
            20'h010: rd = 32'(min_width);
            20'h014: rd = 32'(low_width);
            20'h018: rd = 32'(high_width);
`ifdef FADS_SORT_DELAY_EN
            20'h01C: rd = 32'(sort_delay);
`endif
            20'h020: rd = 32'(sort_dur);
            20'h100: rd = 32'(c_tot);
            20'h104: rd = 32'(c_pos);
            20'h108: rd = 32'(c_short);
            20'h10C: rd = 32'(c_long);
            20'h110: rd = 32'(c_sorted);
            20'h114: rd = 32'(c_missed);
            default: ;
        endcase
        for (int c = 0; c < CH; c++) begin
            if (addr == 20'(64 + 8*c))  rd = 32'($signed(ch_low[c]));
            if (addr == 20'(68 + 8*c))  rd = 32'($signed(ch_high[c]));
            if (addr == 20'(512 + 4*c)) rd = 32'($signed(peak[c]));
        end
    end

    // One-cycle acknowledge with read data aligned to it
    always_ff @(posedge adc_clk_i) begin
        if (adc_rst_i) begin
            sys.sys_ack   <= 1'b0;
            sys.sys_rdata <= '0;
        end else begin
            sys.sys_ack   <= sys.sys_wen | sys.sys_ren;
            sys.sys_rdata <= sys.sys_ren ? rd : '0;
        end
    end
endmodule

// File: tb/tb_red_pitaya_fads_mc.sv
// Directed bench for red_pitaya_fads_mc (CH=2, DW=14, CW=32).
module tb_red_pitaya_fads_mc;
    localparam int CH = 2;
    localparam int DW = 14;
    localparam int CW = 32;
`ifdef FADS_SORT_DELAY_EN
    localparam int LAT3 = 5;   // EVAL -> trig with sort_delay=3
    localparam int LAT0 = 2;   // EVAL -> trig with sort_delay=0
`else
    localparam int LAT3 = 1;
    localparam int LAT0 = 1;
`endif

    logic             adc_clk_i = 1'b0;
    logic             adc_rst_i = 1'b1;
    logic [CH*DW-1:0] adc_dat_i = '0;
    logic             sort_trig_o, sort_busy_o;
    logic [31:0]      rdv;
    logic             ack_seen;
    int               errors = 0;
    int               checks = 0;
    int               f, h;

    red_pitaya_fads_mc_if sys ();

    red_pitaya_fads_mc #(.CH(CH), .DW(DW), .CW(CW)) dut (
        .adc_clk_i   (adc_clk_i),
        .adc_rst_i   (adc_rst_i),
        .adc_dat_i   (adc_dat_i),
        .sort_trig_o (sort_trig_o),
        .sort_busy_o (sort_busy_o),
        .sys         (sys)
    );

    always #5 adc_clk_i = ~adc_clk_i;

    task automatic tick();
        @(posedge adc_clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic adc(input int g, input int c1);
        adc_dat_i = {c1[DW-1:0], g[DW-1:0]};
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        sys.sys_addr  = a;
        sys.sys_wdata = d;
        sys.sys_wen   = 1'b1;
        tick();
        sys.sys_wen   = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        sys.sys_addr = a;
        sys.sys_ren  = 1'b1;
        tick();
        d        = sys.sys_rdata;
        ack_seen = sys.sys_ack;
        sys.sys_ren  = 1'b0;
    endtask

    task automatic chk_rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
        rd(a, rdv);
        check(tag, rdv, exp);
    endtask

    // n above-threshold gate samples, then back to idle
    task automatic drop(input int n, input int g, input int c1, input int idle);
        for (int i = 0; i < n; i++) begin
            adc(g, c1);
            tick();
        end
        adc(idle, 0);
    endtask

    // i=1 is the EVAL cycle when called right after drop()
    task automatic watch(input int n, output int first, output int highs);
        first = 0;
        highs = 0;
        for (int i = 1; i <= n; i++) begin
            tick();
            if (sort_trig_o) begin
                if (first == 0) first = i;
                highs++;
            end
        end
    endtask

    initial begin
        sys.sys_addr  = '0;
        sys.sys_wdata = '0;
        sys.sys_sel   = 4'hF;
        sys.sys_wen   = 1'b0;
        sys.sys_ren   = 1'b0;
        repeat (3) tick();
        adc_rst_i = 1'b0;

        // reset state
        check("rst_trig",  {31'd0, sort_trig_o}, 32'd0);
        check("rst_busy",  {31'd0, sort_busy_o}, 32'd0);
        check("rst_ack",   {31'd0, sys.sys_ack}, 32'd0);
        check("rst_err",   {31'd0, sys.sys_err}, 32'd0);
        check("rst_rdata", sys.sys_rdata, 32'd0);

        // defaults and bus timing
        chk_rd("ctrl_def", 32'h00, 32'd1);
        check("ack_rd", {31'd0, ack_seen}, 32'd1);
        tick();
        check("ack_pulse", {31'd0, sys.sys_ack}, 32'd0);
        chk_rd("status_def",  32'h04, 32'd0);
        chk_rd("mask_def",    32'h08, 32'd3);
        chk_rd("thr_def",     32'h0C, 32'd15);
        chk_rd("minw_def",    32'h10, 32'd1);
        chk_rd("highw_def",   32'h18, 32'hFFFFFFFF);
        chk_rd("dur_def",     32'h20, 32'd125);
        chk_rd("chlow0_def",  32'h40, 32'd16);
        chk_rd("chhigh1_def", 32'h4C, 32'd255);
        chk_rd("unmapped",    32'h300, 32'd0);

        // positive droplet, delayed sort pulse
        wr(32'h00, 32'd3);
        wr(32'h1C, 32'd3);
        wr(32'h20, 32'd5);
`ifdef FADS_SORT_DELAY_EN
        chk_rd("delay_rb", 32'h1C, 32'd3);
`else
        chk_rd("delay_rb", 32'h1C, 32'd0);
`endif
        drop(10, 100, 50, 0);
        watch(20, f, h);
        check("t1_rise", 32'(f), 32'(1 + LAT3));
        check("t1_len",  32'(h), 32'd5);
        chk_rd("t1_total",  32'h100, 32'd1);
        chk_rd("t1_pos",    32'h104, 32'd1);
        chk_rd("t1_sorted", 32'h110, 32'd1);
        chk_rd("t1_peak0",  32'h200, 32'd100);
        chk_rd("t1_peak1",  32'h204, 32'd50);

        // channel window rejection, then mask it off
        wr(32'h00, 32'd7);
        chk_rd("clr_reads0", 32'h00, 32'd3);
        wr(32'h08, 32'd3);
        drop(10, 100, 300, 0);
        watch(20, f, h);
        check("t2_nopulse", 32'(h), 32'd0);
        chk_rd("t2_total", 32'h100, 32'd1);
        chk_rd("t2_pos",   32'h104, 32'd0);
        wr(32'h08, 32'd1);
        drop(10, 100, 300, 0);
        watch(20, f, h);
        check("t2m_pulse", 32'(h), 32'd5);
        chk_rd("t2m_pos",   32'h104, 32'd1);
        chk_rd("t2m_total", 32'h100, 32'd2);

        // noise, short and long droplets
        wr(32'h00, 32'd7);
        wr(32'h10, 32'd4);
        drop(3, 100, 50, 0);
        watch(5, f, h);
        chk_rd("t3_noise_total", 32'h100, 32'd0);
        chk_rd("t3_noise_state", 32'h04, 32'd0);
        wr(32'h10, 32'd1);
        wr(32'h18, 32'd8);
        drop(9, 100, 50, 0);
        watch(10, f, h);
        chk_rd("t3_long",  32'h10C, 32'd1);
        chk_rd("t3_total", 32'h100, 32'd1);
        chk_rd("t3_pos",   32'h104, 32'd0);
        wr(32'h14, 32'd5);
        drop(3, 100, 50, 0);
        watch(5, f, h);
        chk_rd("t3_short", 32'h108, 32'd1);
        wr(32'h14, 32'd0);
        wr(32'h18, 32'hFFFFFFFF);

        // missed droplet during SORT
        wr(32'h00, 32'd7);
        wr(32'h1C, 32'd0);
        wr(32'h20, 32'd20);
        drop(10, 100, 50, 0);
        watch(3, f, h);
        check("t4_busy", {31'd0, sort_busy_o}, 32'd1);
        drop(3, 100, 50, 0);
        watch(25, f, h);
        chk_rd("t4_missed", 32'h114, 32'd1);
        chk_rd("t4_total",  32'h100, 32'd1);
        chk_rd("t4_sorted", 32'h110, 32'd1);

        // clear on the same edge as a missed rise
        drop(10, 100, 50, 0);
        watch(3, f, h);
        adc(100, 50);
        sys.sys_addr  = 32'h00;
        sys.sys_wdata = 32'd7;
        sys.sys_wen   = 1'b1;
        tick();
        sys.sys_wen   = 1'b0;
        tick();
        tick();
        adc(0, 0);
        watch(25, f, h);
        chk_rd("t4c_missed", 32'h114, 32'd0);
        chk_rd("t4c_total",  32'h100, 32'd0);

        // reset in the middle of SORT
        drop(10, 100, 50, 0);
        watch(4, f, h);
        check("t5_trig_pre", {31'd0, sort_trig_o}, 32'd1);
        adc_rst_i = 1'b1;
        tick();
        check("t5_trig_rst", {31'd0, sort_trig_o}, 32'd0);
        check("t5_busy_rst", {31'd0, sort_busy_o}, 32'd0);
        adc_rst_i = 1'b0;
        chk_rd("t5_dur", 32'h20, 32'd125);
        check("t5_ack", {31'd0, ack_seen}, 32'd1);
        chk_rd("t5_thr", 32'h0C, 32'd15);
        chk_rd("t5_sorted", 32'h110, 32'd0);

        // negative thresholds and sign-extended readback
        adc(-200, 0);
        wr(32'h0C, 32'hFFFFFF9C);
        chk_rd("t6_thr", 32'h0C, 32'hFFFFFF9C);
        drop(5, -50, -20, -200);
        watch(5, f, h);
        chk_rd("t6_total", 32'h100, 32'd1);
        chk_rd("t6_peak0", 32'h200, 32'hFFFFFFCE);
        chk_rd("t6_peak1", 32'h204, 32'hFFFFFFEC);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
